wfifo_ingress: RTL and testbench
================================

Name: wfifo_ingress

Overview:
Write-side ingress stage of the asynchronous FIFO. It sits directly upstream of the write-pointer/full-flag block and runs entirely in the wclk domain.
- Accepts a valid/ready stream from the producer, buffers it in a 2-entry skid buffer, and drives winc/wdata into the FIFO write port.
- Decodes the Gray write pointer and the synchronized Gray read pointer to produce a fill level, a programmable almost-full flag and a saturating stall counter.

Parameters:
ADDR_WIDTH, 9, FIFO address width; DEPTH = 2**ADDR_WIDTH; pointer width is ADDR_WIDTH+1.
DATA_WIDTH, 8, width of each data word.
STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
wclk  input  1  write-domain clock.
wrst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer word valid.
in_data  input  DATA_WIDTH  producer word.
in_ready  output  1  ingress can accept a word (registered).
winc  output  1  write strobe to the FIFO write port.
wdata  output  DATA_WIDTH  data to the FIFO memory.
wfull  input  1  registered full flag from the write-pointer block.
wptr  input  ADDR_WIDTH+1  Gray write pointer from the write-pointer block.
wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wclk.
af_thresh  input  ADDR_WIDTH+1  almost-full threshold, quasi-static.
wlevel  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH.
wafull  output  1  registered almost-full flag.
stall_cnt  output  STALL_CNT_W  saturating count of stalled cycles.
stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (async, wrst_n low): both skid entries invalid; in_ready=0 while in reset, 1 on the first wclk edge after release; winc=0; wdata=0; wlevel=0; wafull=0; stall_cnt=0.
- Skid buffer has two entries: head (drives wdata) and skid.
  - in_ready is registered and equals !skid_valid.
  - Input handshake: in_valid & in_ready.
  - Output handshake: winc = head_valid & ~wfull. winc is combinational from head_valid and wfull. Every asserted winc is a committed write, and winc is never asserted while wfull=1.
- Per-edge update rules:
  - Accept with head empty, or head draining that edge: word loads into head.
  - Accept while head is held (wfull=1): word loads into skid and in_ready drops next cycle.
  - Head drains while skid is valid: skid moves to head; skid_valid clears, so in_ready=1 next cycle.
  - Simultaneous accept and drain with skid empty: new word goes to head (pass-through). Throughput is 1 word/cycle.
- Latency: a word accepted at edge N is presented on wdata with head_valid at cycle N+1. It is written at the first subsequent edge where wfull=0.
- Ordering: strict FIFO, no drops, no duplicates. wdata holds its value while head_valid & wfull.
- Level calculation:
  - wbin = gray2bin(wptr) and rbin = gray2bin(wq2_rptr), both ADDR_WIDTH+1 bits.
  - wlevel <= (wbin - rbin) modulo 2**(ADDR_WIDTH+1). This is correct across pointer wrap because the extra MSB is retained.
  - wlevel is pessimistic by the synchronizer delay and may never exceed DEPTH. A value above DEPTH indicates corrupt pointers; assertion only, no RTL clamp.
- wafull <= (wlevel_next >= af_thresh). Registered on the same edge as wlevel. af_thresh=0 forces wafull=1 after reset release.
- Stall counter:
  - stall_cnt increments when head_valid & wfull, and saturates at all-ones.
  - stall_clr has priority and clears it to 0, even if a stall occurs the same cycle.
- Reset mid-operation: all buffered words are discarded and all outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package wfifo_pkg holds:
  - function gray2bin (parameterized by width via a loop, returning binary).
  - localparam DEPTH derivation helper.
  - typedef of the skid entry struct {logic valid; logic [DATA_WIDTH-1:0] data;} where the tool allows parameterized typedefs; otherwise plain registers.
- One natural sub-module: wfifo_skid_buf (the 2-entry valid/ready buffer). Level, almost-full and stall logic stay in the top.

Test Plan:
- Streaming, ADDR_WIDTH=4, wfull=0, in_valid held for 20 cycles with data 0x00..0x13 -> winc high on 20 consecutive cycles, wdata 0x00..0x13 in order, in_ready stays 1.
- Backpressure: assert wfull for 3 cycles while streaming 0xA0,0xA1,0xA2 -> wdata holds 0xA0, skid captures 0xA1, in_ready=0 on the cycle after the skid fills, winc=0 throughout. After wfull=0, 0xA0,0xA1,0xA2 are written in order with no loss. stall_cnt=3.
- Level wrap: wptr=Gray(3), wq2_rptr=Gray(29) (5-bit pointers) -> wlevel=6 one cycle later. wptr=Gray(16), wq2_rptr=Gray(0) -> wlevel=16.
- Almost full: af_thresh=12; level steps 11->12->11 -> wafull 0->1->0, aligned with wlevel.
- Stall counter: STALL_CNT_W=4, hold wfull with head valid for 20 cycles -> stall_cnt saturates at 15. stall_clr pulsed during a stall -> 0 on the next cycle.
- Reset mid-stream: drop wrst_n with both entries full -> winc=0, wlevel=0, in_ready=0 immediately. After release, the next accepted word is the first written and no stale data appears.

Source files
------------

// File: rtl/wfifo_pkg.sv
// Shared helpers for the write-side ingress of the asynchronous FIFO.
package wfifo_pkg;

  // Number of FIFO entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

  // Gray to binary conversion; operands narrower than 32 bits are zero-extended,
  // which leaves the result of the low bits unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wfifo_skid_buf.sv
// Two-entry valid/ready skid buffer feeding the FIFO write port.
module wfifo_skid_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  wfull,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  head_valid_n;
  logic [DATA_WIDTH-1:0] head_data_n;
  logic                  skid_valid_n;
  logic [DATA_WIDTH-1:0] skid_data_n;
  logic                  accept;
  logic                  drain;

  assign accept = in_valid & in_ready;
  assign drain  = head_valid & ~wfull;

  // Next-state of head/skid entries from the accept and drain handshakes.
  always_comb begin
    head_valid_n = head_valid;
    head_data_n  = head_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (drain) begin
      if (skid_valid) begin
        head_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        head_data_n = in_data;
      end else begin
        head_valid_n = 1'b0;
      end
    end else if (!head_valid) begin
      if (accept) begin
        head_valid_n = 1'b1;
        head_data_n  = in_data;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
  end

  // Entry registers; in_ready mirrors the free skid slot one cycle ahead.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      head_valid <= head_valid_n;
      head_data  <= head_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= ~skid_valid_n;
    end
  end

endmodule

// File: rtl/wfifo_ingress.sv
// Write-side ingress: skid-buffered write port, fill level, almost-full, stall stats.
module wfifo_ingress
  import wfifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   winc,
  output logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   wfull,
  input  logic [ADDR_WIDTH:0]    wptr,
  input  logic [ADDR_WIDTH:0]    wq2_rptr,
  input  logic [ADDR_WIDTH:0]    af_thresh,
  output logic [ADDR_WIDTH:0]    wlevel,
  output logic                   wafull,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic             head_valid;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] wlevel_next;
  logic             stall;

  wfifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wfull      (wfull),
    .head_valid (head_valid),
    .head_data  (wdata)
  );

  // Write strobe is combinational so a full flag blocks the same cycle.
  assign winc  = head_valid & ~wfull;
  assign stall = head_valid & wfull;

  // Modulo difference of binary pointers; the extra MSB keeps wrap correct.
  assign wbin        = PTR_W'(gray2bin(32'(wptr)));
  assign rbin        = PTR_W'(gray2bin(32'(wq2_rptr)));
  assign wlevel_next = PTR_W'(wbin - rbin);

  // Fill level and almost-full flag registered together.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel <= '0;
      wafull <= 1'b0;
    end else begin
      wlevel <= wlevel_next;
      wafull <= (wlevel_next >= af_thresh);
    end
  end

  // Saturating stall counter; clear wins over a concurrent stall.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  // A level above DEPTH can only come from corrupt pointers.
  a_level_in_range: assert property (@(posedge wclk) disable iff (!wrst_n)
    wlevel <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_wfifo_ingress.sv
// Self-checking bench for wfifo_ingress with a queue-based reference model.
module tb_wfifo_ingress;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int PW = AW + 1;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] af_thresh = 5'd16;
  logic [PW-1:0] wlevel;
  logic          wafull;
  logic [SW-1:0] stall_cnt;
  logic          stall_clr = 1'b0;

  // Binary pointers owned by the bench; the DUT sees their Gray codes.
  logic [PW-1:0] wb = '0;
  logic [PW-1:0] rb = '0;
  assign wptr     = wb ^ (wb >> 1);
  assign wq2_rptr = rb ^ (rb >> 1);

  always #5 wclk = ~wclk;

  wfifo_ingress #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STALL_CNT_W (SW)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .wptr      (wptr),
    .wq2_rptr  (wq2_rptr),
    .af_thresh (af_thresh),
    .wlevel    (wlevel),
    .wafull    (wafull),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words held by the ingress, in arrival order.
  logic [DW-1:0] q[$];
  logic [DW-1:0] wlog[$];
  logic [DW-1:0] last_head = '0;
  bit            rdy_m = 1'b0;
  int            lvl_m = 0;
  bit            af_m = 1'b0;
  int            stall_m = 0;

  initial forever begin
    @(posedge wclk or negedge wrst_n);
    if (!wrst_n) begin
      q.delete();
      last_head = '0;
      rdy_m     = 1'b0;
      lvl_m     = 0;
      af_m      = 1'b0;
      stall_m   = 0;
    end else begin
      bit            drain;
      bit            acc;
      bit            stl;
      logic [PW-1:0] d;
      drain = (q.size() > 0) && !wfull;
      stl   = (q.size() > 0) && wfull;
      acc   = in_valid && rdy_m;
      if (drain) wlog.push_back(q.pop_front());
      if (acc) q.push_back(in_data);
      if (q.size() > 0) last_head = q[0];
      rdy_m = (q.size() < 2);
      d     = wb - rb;
      lvl_m = int'(d);
      af_m  = (lvl_m >= int'(af_thresh));
      if (stall_clr) stall_m = 0;
      else if (stl && stall_m < 15) stall_m++;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial forever begin
    @(negedge wclk);
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
    chk("winc", 32'(winc), 32'((q.size() > 0) && !wfull));
    chk("wdata", 32'(wdata), 32'((q.size() > 0) ? q[0] : last_head));
    chk("wlevel", 32'(wlevel), 32'(lvl_m));
    chk("wafull", 32'(wafull), 32'(af_m));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    chk(name, (idx < wlog.size()) ? 32'(wlog[idx]) : 32'hDEAD_BEEF, exp);
  endtask

  initial begin
    // Reset and release.
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    wrst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Streaming with no backpressure.
    wlog.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_count", 32'(wlog.size()), 32'd20);
    for (int i = 0; i < 20; i++) chk_log("stream_word", i, 32'(i));

    // Backpressure over three stalled edges.
    wlog.delete();
    wfull    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    tick();
    in_data = 8'hA1;
    tick();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'hA2;
    tick();
    chk("bp_wdata_hold", 32'(wdata), 32'hA0);
    tick();
    wfull = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("bp_count", 32'(wlog.size()), 32'd3);
    chk_log("bp_word0", 0, 32'hA0);
    chk_log("bp_word1", 1, 32'hA1);
    chk_log("bp_word2", 2, 32'hA2);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;

    // Level across pointer wrap.
    wb = 5'd3;
    rb = 5'd29;
    tick();
    chk("wrap_level", 32'(wlevel), 32'd6);
    wb = 5'd16;
    rb = 5'd0;
    tick();
    chk("full_level", 32'(wlevel), 32'd16);

    // Almost-full threshold crossing.
    af_thresh = 5'd12;
    wb = 5'd11;
    tick();
    chk("af_11", 32'(wafull), 32'd0);
    wb = 5'd12;
    tick();
    chk("af_12", 32'(wafull), 32'd1);
    wb = 5'd11;
    tick();
    chk("af_back", 32'(wafull), 32'd0);
    af_thresh = 5'd0;
    wb = 5'd0;
    rb = 5'd0;
    tick();
    chk("af_zero", 32'(wafull), 32'd1);
    af_thresh = 5'd12;

    // Stall counter saturation and clear priority.
    wfull    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    stall_clr = 1'b1;
    tick();
    chk("stall_clr", 32'(stall_cnt), 32'd0);
    stall_clr = 1'b0;
    tick();
    chk("stall_restart", 32'(stall_cnt), 32'd1);
    wfull = 1'b0;
    repeat (2) tick();

    // Asynchronous reset with both entries occupied.
    wfull    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    wb = 5'd5;
    tick();
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    wrst_n = 1'b0;
    #1;
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_wlevel", 32'(wlevel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    tick();
    tick();
    wrst_n = 1'b1;
    wfull  = 1'b0;
    wlog.delete();
    tick();
    in_valid = 1'b1;
    in_data  = 8'h88;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("post_rst_count", 32'(wlog.size()), 32'd1);
    chk_log("post_rst_word", 0, 32'h88);

    // Randomized traffic, pointers and control.
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      wfull     = ($urandom_range(0, 9) < 3);
      stall_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wb = 5'($urandom);
        rb = wb - 5'($urandom_range(0, 16));
      end
      if ($urandom_range(0, 199) == 0) af_thresh = 5'($urandom_range(0, 16));
      tick();
    end
    in_valid  = 1'b0;
    wfull     = 1'b0;
    stall_clr = 1'b0;
    repeat (4) tick();
    chk("final_drained", 32'(winc), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
